// File: rtl/prog_loader.sv
// Boot-path loader: takes an address word followed by program words, writes them
// to datapath memory, then loads PC and releases the CPU. Optional stream
// checksum word enabled by PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter logic [15:0] BOOT_PC = 16'h0000,
  parameter int unsigned CNT_W   = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_data,
  output logic             pc_load,
  output logic [15:0]      pc_data,
  output logic             cpu_run,
  output logic             busy,
  output logic [CNT_W-1:0] word_count,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LOAD,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] ptr;
  logic        xfer;
  logic        restart;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [15:0] csum;
`endif

  assign busy     = (state == S_ADDR) || (state == S_LOAD) || (state == S_CSUM);
  assign in_ready = busy;
  assign cpu_run  = (state == S_DONE);
  assign pc_data  = BOOT_PC;
  assign xfer     = in_valid && in_ready;
  assign restart  = start && !busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_ADDR;
      S_ADDR: if (xfer) state_nxt = in_last ? S_DONE : S_LOAD;
      S_LOAD: begin
        if (xfer && in_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_nxt = S_CSUM;
`else
          state_nxt = S_DONE;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CSUM: if (xfer) state_nxt = (in_data == csum) ? S_DONE : S_ERR;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Write port is registered: a word accepted at edge N appears on the memory
  // bus during the following cycle, so full-rate streams give one write per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      pc_load    <= 1'b0;
      word_count <= '0;
      err        <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      mem_we  <= 1'b0;
      pc_load <= (state_nxt == S_DONE) && (state != S_DONE);
      if (restart) begin
        word_count <= '0;
        err        <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum       <= '0;
`endif
      end
      if (xfer) begin
        case (state)
          S_ADDR: ptr <= in_data;
          S_LOAD: begin
            mem_we     <= 1'b1;
            mem_addr   <= ptr;
            mem_data   <= in_data;
            ptr        <= ptr + 16'd1;
            word_count <= word_count + CNT_W'(1);
            if (ptr == '1) err <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum       <= csum + in_data;
`endif
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          S_CSUM: if (in_data != csum) err <= 1'b1;
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: memory writes, PC hand-off, wrap error,
// throttled streams, mid-session reset and (when enabled) checksum handling.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, mem_we, pc_load, cpu_run, busy, err;
  logic [15:0] mem_addr, mem_data, pc_data;
  logic [16:0] word_count;

  int          checks = 0;
  int          failures = 0;
  int          pc_pulses = 0;
  logic [15:0] tb_sum = '0;
  logic [31:0] wr_q[$];
  logic [31:0] exp_q[$];

  prog_loader #(.BOOT_PC(16'h0000), .CNT_W(17)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .pc_load(pc_load), .pc_data(pc_data), .cpu_run(cpu_run),
    .busy(busy), .word_count(word_count), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) wr_q.push_back({mem_addr, mem_data});
    if (pc_load) pc_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_n"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), wr_q[i], exp_q[i]);
    wr_q.delete();
    exp_q.delete();
  endtask

  // Presents a word at a falling edge and returns at the falling edge after it is taken.
  task automatic send(input logic [15:0] d, input logic last);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_wait", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_data(input logic [15:0] d, input logic last);
    tb_sum = tb_sum + d;
    send(d, last);
  endtask

  task automatic end_stream();
`ifdef PROG_LOADER_CHECKSUM_EN
    send(tb_sum, 1'b0);
`endif
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    tb_sum = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_run", cpu_run, 0);
    check("rst_busy", busy, 0);
    check("rst_we", mem_we, 0);
    check("rst_pcload", pc_load, 0);
    check("rst_pcdata", pc_data, 16'h0000);
    check("rst_err", err, 0);
    check("rst_count", word_count, 0);

    // basic program
    pulse_start();
    check("addr_busy", busy, 1);
    check("addr_ready", in_ready, 1);
    send(16'h3000, 1'b0);
    send_data(16'h1261, 1'b0);
    send_data(16'h1262, 1'b1);
    end_stream();
    check("done_pcload", pc_load, 1);
    check("done_run", cpu_run, 1);
    check("done_busy", busy, 0);
    check("done_ready", in_ready, 0);
    check("done_count", word_count, 2);
    check("done_pcdata", pc_data, 16'h0000);
    check("done_err", err, 0);
    in_valid = 1'b1;
    in_data  = 16'hdead;
    @(negedge clk);
    check("done_pcload_off", pc_load, 0);
    check("done_run_hold", cpu_run, 1);
    in_valid = 1'b0;
    @(negedge clk);
    exp_q.push_back(32'h3000_1261);
    exp_q.push_back(32'h3001_1262);
    check_writes("basic");
    check("basic_pulses", pc_pulses, 1);

    // address wrap
    pulse_start();
    check("reload_run", cpu_run, 0);
    check("reload_err", err, 0);
    send(16'hffff, 1'b0);
    send_data(16'h1111, 1'b0);
    send_data(16'h2222, 1'b1);
    end_stream();
    check("wrap_run", cpu_run, 1);
    check("wrap_err", err, 1);
    check("wrap_count", word_count, 2);
    @(negedge clk);
    exp_q.push_back(32'hffff_1111);
    exp_q.push_back(32'h0000_2222);
    check_writes("wrap");

    // throttled stream with a start pulse during LOAD
    pulse_start();
    send(16'h4000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_data(16'h0a00 + 16'(i), i == 3);
      if (i < 3) begin
        in_valid = 1'b0;
        if (i == 1) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    end_stream();
    check("thr_count", word_count, 4);
    check("thr_run", cpu_run, 1);
    check("thr_err", err, 0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) exp_q.push_back({16'h4000 + 16'(i), 16'h0a00 + 16'(i)});
    check_writes("thr");
    check("thr_pulses", pc_pulses, 3);

    // reset in the middle of LOAD
    pulse_start();
    send(16'h5000, 1'b0);
    send_data(16'h000a, 1'b0);
    send_data(16'h000b, 1'b0);
    send_data(16'h000c, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_run", cpu_run, 0);
    check("mrst_ready", in_ready, 0);
    check("mrst_count", word_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_q.push_back(32'h5000_000a);
    exp_q.push_back(32'h5001_000b);
    exp_q.push_back(32'h5002_000c);
    check_writes("mrst");
    check("mrst_pulses", pc_pulses, 3);
    pulse_start();
    send(16'h6000, 1'b0);
    send_data(16'h0077, 1'b1);
    end_stream();
    check("again_pcload", pc_load, 1);
    check("again_count", word_count, 1);
    @(negedge clk);
    exp_q.push_back(32'h6000_0077);
    check_writes("again");
    check("again_pulses", pc_pulses, 4);

    // empty program: address word carries in_last
    pulse_start();
    send(16'h7000, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("empty_pcload", pc_load, 1);
    check("empty_count", word_count, 0);
    @(negedge clk);
    check_writes("empty");

`ifdef PROG_LOADER_CHECKSUM_EN
    pulse_start();
    send(16'h0000, 1'b0);
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b1);
    send(16'h0003, 1'b0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("csum_ok_run", cpu_run, 1);
    check("csum_ok_pcload", pc_load, 1);
    check("csum_ok_err", err, 0);
    @(negedge clk);
    wr_q.delete();
    pulse_start();
    send(16'h0000, 1'b0);
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b1);
    send(16'h0004, 1'b0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("csum_bad_err", err, 1);
    check("csum_bad_run", cpu_run, 0);
    check("csum_bad_busy", busy, 0);
    check("csum_bad_pcload", pc_load, 0);
    @(negedge clk);
    check("csum_bad_pulses", pc_pulses, 6);
    wr_q.delete();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
